// File: rtl/rsa_exp_cached_pkg.sv
// Shared definitions for the cached RSA modular-exponentiation slice.
package rsa_exp_cached_pkg;

    // Top-level sequencer states.
    typedef logic [2:0] state_t;

    localparam state_t StIdle    = 3'd0;
    localparam state_t StCheck   = 3'd1;
    localparam state_t StPrecomp = 3'd2;
    localparam state_t StExp     = 3'd3;
    localparam state_t StDone    = 3'd4;

    // Width needed to carry the R2 exponent 2*mod_width.
    function automatic int unsigned r2_pow_width(input int unsigned mod_width);
        return $clog2(2 * mod_width) + 1;
    endfunction

    // R2 = 2^(2*mod_width) mod N, so the exponent is 2*mod_width.
    function automatic int unsigned r2_pow(input int unsigned mod_width);
        return 2 * mod_width;
    endfunction

endpackage

// File: rtl/rsa_mont_exp.sv
// Left-to-right Montgomery modular exponentiation with a bit-serial Montgomery
// multiplier (MOD_WIDTH steps plus one settle cycle per product).
// Requires N odd and R2 = 2^(2*MOD_WIDTH) mod N.
module rsa_mont_exp #(
    parameter int unsigned MOD_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [MOD_WIDTH-1:0] r2_i,
    input  logic [MOD_WIDTH-1:0] msg_i,
    input  logic [MOD_WIDTH-1:0] key_i,
    input  logic [MOD_WIDTH-1:0] modulus_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [MOD_WIDTH-1:0] result_o
);

    localparam int unsigned CntWidth = $clog2(MOD_WIDTH + 1);
    localparam int unsigned BitWidth = $clog2(MOD_WIDTH);

    localparam logic [2:0] MIdle     = 3'd0;
    localparam logic [2:0] MToMont   = 3'd1;
    localparam logic [2:0] MOne      = 3'd2;
    localparam logic [2:0] MSquare   = 3'd3;
    localparam logic [2:0] MMult     = 3'd4;
    localparam logic [2:0] MFromMont = 3'd5;
    localparam logic [2:0] MDone     = 3'd6;

    logic [2:0]           st_q, st_d;
    logic [MOD_WIDTH-1:0] key_q, r2_q, n_q;
    logic [MOD_WIDTH-1:0] x_q, x_d;
    logic [MOD_WIDTH-1:0] res_q, res_d;
    logic [BitWidth-1:0]  bit_q, bit_d;
    logic [MOD_WIDTH-1:0] a_q, b_q;
    logic [MOD_WIDTH+1:0] t_q;
    logic [CntWidth-1:0]  cnt_q;
    logic [MOD_WIDTH+1:0] sum_ab, sum_n;
    logic                 mul_done;
    logic [MOD_WIDTH-1:0] mul_res;
    logic                 start, step_bit;
    logic [MOD_WIDTH-1:0] op_a, op_b;

    // One Montgomery step: t = (t + a0*b + q*N) / 2, with t kept below 2N.
    always_comb begin
        sum_ab   = t_q + (a_q[0] ? {2'b00, b_q} : '0);
        sum_n    = sum_ab + (sum_ab[0] ? {2'b00, n_q} : '0);
        mul_done = (cnt_q == CntWidth'(MOD_WIDTH));
        mul_res  = (t_q >= {2'b00, n_q}) ? (t_q[MOD_WIDTH-1:0] - n_q) : t_q[MOD_WIDTH-1:0];
    end

    // Sequencer: x = msg*R, acc = R, square/multiply per key bit, then leave the domain.
    always_comb begin
        st_d     = st_q;
        x_d      = x_q;
        res_d    = res_q;
        bit_d    = bit_q;
        start    = 1'b0;
        step_bit = 1'b0;
        op_a     = a_q;
        op_b     = b_q;
        case (st_q)
            MIdle: begin
                if (valid_i) begin
                    start = 1'b1;
                    op_a  = msg_i;
                    op_b  = r2_i;
                    st_d  = MToMont;
                end
            end
            MToMont: begin
                if (mul_done) begin
                    x_d   = mul_res;
                    start = 1'b1;
                    op_a  = MOD_WIDTH'(1);
                    op_b  = r2_q;
                    st_d  = MOne;
                end
            end
            MOne: begin
                if (mul_done) begin
                    start = 1'b1;
                    op_a  = mul_res;
                    op_b  = mul_res;
                    bit_d = BitWidth'(MOD_WIDTH - 1);
                    st_d  = MSquare;
                end
            end
            MSquare: begin
                if (mul_done) begin
                    if (key_q[bit_q]) begin
                        start = 1'b1;
                        op_a  = mul_res;
                        op_b  = x_q;
                        st_d  = MMult;
                    end else begin
                        step_bit = 1'b1;
                    end
                end
            end
            MMult: begin
                if (mul_done) begin
                    step_bit = 1'b1;
                end
            end
            MFromMont: begin
                if (mul_done) begin
                    res_d = mul_res;
                    st_d  = MDone;
                end
            end
            MDone: begin
                if (ready_i) begin
                    st_d = MIdle;
                end
            end
            default: st_d = MIdle;
        endcase
        // Advance to the next key bit, or multiply by 1 to leave Montgomery form.
        if (step_bit) begin
            start = 1'b1;
            op_a  = mul_res;
            if (bit_q == '0) begin
                op_b = MOD_WIDTH'(1);
                st_d = MFromMont;
            end else begin
                op_b  = mul_res;
                bit_d = bit_q - 1'b1;
                st_d  = MSquare;
            end
        end
    end

    // State, operand capture and the serial multiplier datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= MIdle;
            key_q <= '0;
            r2_q  <= '0;
            n_q   <= '0;
            x_q   <= '0;
            res_q <= '0;
            bit_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            t_q   <= '0;
            cnt_q <= CntWidth'(MOD_WIDTH);
        end else begin
            st_q  <= st_d;
            x_q   <= x_d;
            res_q <= res_d;
            bit_q <= bit_d;
            if (st_q == MIdle && valid_i) begin
                key_q <= key_i;
                r2_q  <= r2_i;
                n_q   <= modulus_i;
            end
            if (start) begin
                a_q   <= op_a;
                b_q   <= op_b;
                t_q   <= '0;
                cnt_q <= '0;
            end else if (!mul_done) begin
                a_q   <= a_q >> 1;
                t_q   <= sum_n >> 1;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        ready_o  = (st_q == MIdle);
        valid_o  = (st_q == MDone);
        result_o = res_q;
    end

endmodule

// File: rtl/rsa_r2_cache.sv
// Single-entry cache of the last (N, R2) pair, with flush and write ports.
module rsa_r2_cache #(
    parameter int unsigned MOD_WIDTH = 256,
    parameter bit          CACHE_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [MOD_WIDTH-1:0] wr_n_i,
    input  logic [MOD_WIDTH-1:0] wr_r2_i,
    input  logic [MOD_WIDTH-1:0] lookup_n_i,
    output logic                 hit_o,
    output logic [MOD_WIDTH-1:0] r2_o
);

    logic                 valid_q;
    logic [MOD_WIDTH-1:0] n_q;
    logic [MOD_WIDTH-1:0] r2_q;

    // Flush takes priority over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            n_q     <= '0;
            r2_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (wr_en_i) begin
            valid_q <= 1'b1;
            n_q     <= wr_n_i;
            r2_q    <= wr_r2_i;
        end
    end

    // Lookup is purely combinational against the stored modulus.
    always_comb begin
        hit_o = CACHE_EN && valid_q && (n_q == lookup_n_i);
        r2_o  = r2_q;
    end

endmodule

// File: rtl/rsa_two_pow_mod.sv
// Computes 2^pow mod N by repeated modular doubling, one doubling per cycle.
// Assumes N is odd and > 1 (the caller rejects other moduli first).
module rsa_two_pow_mod
    import rsa_exp_cached_pkg::*;
#(
    parameter int unsigned MOD_WIDTH = 256,
    parameter int unsigned POW_WIDTH = r2_pow_width(MOD_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [POW_WIDTH-1:0] pow_i,
    input  logic [MOD_WIDTH-1:0] modulus_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [MOD_WIDTH-1:0] result_o
);

    logic                 busy_q;
    logic                 done_q;
    logic [POW_WIDTH-1:0] cnt_q;
    logic [MOD_WIDTH-1:0] r_q;
    logic [MOD_WIDTH-1:0] n_q;
    logic [MOD_WIDTH:0]   dbl;
    logic [MOD_WIDTH-1:0] r_next;

    // r < N, so 2r < 2N and one conditional subtraction reduces it.
    always_comb begin
        dbl    = {r_q, 1'b0};
        r_next = (dbl >= {1'b0, n_q}) ? (dbl[MOD_WIDTH-1:0] - n_q) : dbl[MOD_WIDTH-1:0];
    end

    // Start on valid when idle, double pow times, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            r_q    <= '0;
            n_q    <= '0;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                r_q   <= r_next;
                cnt_q <= cnt_q - 1'b1;
            end
        end else if (done_q) begin
            if (ready_i) begin
                done_q <= 1'b0;
            end
        end else if (valid_i) begin
            busy_q <= 1'b1;
            cnt_q  <= pow_i;
            r_q    <= MOD_WIDTH'(1);
            n_q    <= modulus_i;
        end
    end

    always_comb begin
        valid_o  = done_q;
        result_o = r_q;
    end

endmodule

// File: rtl/rsa_exp_cached.sv
// RSA modular exponentiation (msg^key mod N) over valid/ready, reusing the
// R2 constant of the previous modulus when the same N arrives again.
module rsa_exp_cached
    import rsa_exp_cached_pkg::*;
#(
    parameter int unsigned MOD_WIDTH = 256,
    parameter int unsigned TAG_WIDTH = 4,
    parameter bit          CACHE_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [MOD_WIDTH-1:0] i_msg,
    input  logic [MOD_WIDTH-1:0] i_key,
    input  logic [MOD_WIDTH-1:0] i_modulus,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [MOD_WIDTH-1:0] o_crypto,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_cache_hit,
    output logic                 o_err
);

    typedef logic [MOD_WIDTH-1:0] key_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    localparam int unsigned PowWidth = r2_pow_width(MOD_WIDTH);
    localparam logic [PowWidth-1:0] R2Pow = PowWidth'(r2_pow(MOD_WIDTH));

    state_t state_q, state_d;
    key_t   msg_q, key_q, n_q, r2_q, crypto_q;
    tag_t   tag_q;
    logic   hit_q, err_q, flush_seen_q, mont_sent_q;

    logic   accept, n_bad, cache_hit, cache_wr, r2_start;
    logic   r2_valid, mont_valid, mont_ready, mont_out_valid;
    key_t   cache_r2, r2_res, mont_res;

    always_comb begin
        accept     = i_valid && i_ready;
        n_bad      = !n_q[0] || (n_q <= key_t'(1));
        r2_start   = (state_q == StCheck) && !n_bad && !cache_hit;
        // A flush any time since accept keeps this R2 out of the cache.
        cache_wr   = (state_q == StPrecomp) && r2_valid && !flush_seen_q && !i_flush;
        mont_valid = (state_q == StExp) && !mont_sent_q;
    end

    // Next-state logic for the request sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (accept) state_d = StCheck;
            StCheck: begin
                if (n_bad) begin
                    state_d = StDone;
                end else if (cache_hit) begin
                    state_d = StExp;
                end else begin
                    state_d = StPrecomp;
                end
            end
            StPrecomp: if (r2_valid) state_d = StExp;
            StExp:     if (mont_out_valid) state_d = StDone;
            StDone:    if (o_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State and request/result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            msg_q        <= '0;
            key_q        <= '0;
            n_q          <= '0;
            tag_q        <= '0;
            r2_q         <= '0;
            crypto_q     <= '0;
            hit_q        <= 1'b0;
            err_q        <= 1'b0;
            flush_seen_q <= 1'b0;
            mont_sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                msg_q        <= i_msg;
                key_q        <= i_key;
                n_q          <= i_modulus;
                tag_q        <= i_tag;
                hit_q        <= 1'b0;
                err_q        <= 1'b0;
                flush_seen_q <= i_flush;
            end else if (i_flush) begin
                flush_seen_q <= 1'b1;
            end
            if (state_q == StCheck) begin
                if (n_bad) begin
                    err_q    <= 1'b1;
                    crypto_q <= '0;
                end else if (cache_hit) begin
                    hit_q <= 1'b1;
                    r2_q  <= cache_r2;
                end
            end
            if (state_q == StPrecomp && r2_valid) begin
                r2_q <= r2_res;
            end
            // Hold core valid only until the core has taken this request.
            if (state_q != StExp) begin
                mont_sent_q <= 1'b0;
            end else if (mont_valid && mont_ready) begin
                mont_sent_q <= 1'b1;
            end
            if (state_q == StExp && mont_out_valid) begin
                crypto_q <= mont_res;
            end
        end
    end

    always_comb begin
        i_ready     = (state_q == StIdle);
        o_valid     = (state_q == StDone);
        o_crypto    = crypto_q;
        o_tag       = tag_q;
        o_cache_hit = hit_q;
        o_err       = err_q;
    end

    rsa_r2_cache #(
        .MOD_WIDTH (MOD_WIDTH),
        .CACHE_EN  (CACHE_EN)
    ) u_cache (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (i_flush),
        .wr_en_i    (cache_wr),
        .wr_n_i     (n_q),
        .wr_r2_i    (r2_res),
        .lookup_n_i (n_q),
        .hit_o      (cache_hit),
        .r2_o       (cache_r2)
    );

    rsa_two_pow_mod #(
        .MOD_WIDTH (MOD_WIDTH),
        .POW_WIDTH (PowWidth)
    ) u_r2 (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (r2_start),
        .pow_i     (R2Pow),
        .modulus_i (n_q),
        .valid_o   (r2_valid),
        .ready_i   (1'b1),
        .result_o  (r2_res)
    );

    rsa_mont_exp #(
        .MOD_WIDTH (MOD_WIDTH)
    ) u_mont (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (mont_valid),
        .ready_o   (mont_ready),
        .r2_i      (r2_q),
        .msg_i     (msg_q),
        .key_i     (key_q),
        .modulus_i (n_q),
        .valid_o   (mont_out_valid),
        .ready_i   (1'b1),
        .result_o  (mont_res)
    );

endmodule

// File: tb/tb_rsa_exp_cached.sv
// Directed plus randomized bench for rsa_exp_cached at MOD_WIDTH=8.
module tb_rsa_exp_cached;

    localparam int W  = 8;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic [W-1:0]  i_msg = '0, i_key = '0, i_modulus = '0;
    logic [TW-1:0] i_tag = '0;
    logic          i_flush = 1'b0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [W-1:0]  o_crypto;
    logic [TW-1:0] o_tag;
    logic          o_cache_hit, o_err;

    int errors = 0;
    int checks = 0;
    int r2_pulses = 0;

    // Reference cache state, derived from request history.
    bit           m_cvalid = 1'b0;
    logic [W-1:0] m_cn = '0;

    always #5 clk = ~clk;

    rsa_exp_cached #(
        .MOD_WIDTH (W),
        .TAG_WIDTH (TW),
        .CACHE_EN  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_msg       (i_msg),
        .i_key       (i_key),
        .i_modulus   (i_modulus),
        .i_tag       (i_tag),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_crypto    (o_crypto),
        .o_tag       (o_tag),
        .o_cache_hit (o_cache_hit),
        .o_err       (o_err)
    );

    // Count cycles in which the R2 core is asked to start.
    always @(negedge clk) begin
        if (!rst && dut.r2_start) r2_pulses++;
    end

    function automatic logic [W-1:0] ref_exp(input logic [W-1:0] m, k, n);
        longint unsigned r, b;
        r = 1;
        b = longint'(m) % longint'(n);
        for (int i = 0; i < W; i++) begin
            if (k[i]) r = (r * b) % longint'(n);
            b = (b * b) % longint'(n);
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_r2(input logic [W-1:0] n);
        longint unsigned r;
        r = (64'd1 << (2 * W)) % longint'(n);
        return r[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and return at the negedge where o_valid is first seen.
    task automatic run_req(input logic [W-1:0] m, k, n, input logic [TW-1:0] t,
                           input bit fl, input bit fl_mid, input string nm);
        int          lat, p0, wait_c;
        bit          good, exp_hit, mid_done;
        logic [W-1:0] exp_c;
        good = n[0] && (n > 1);
        if (fl) m_cvalid = 1'b0;
        exp_hit = good && m_cvalid && (m_cn == n);
        exp_c   = good ? ref_exp(m, k, n) : '0;
        i_msg = m; i_key = k; i_modulus = n; i_tag = t; i_flush = fl; i_valid = 1'b1;
        wait_c = 0;
        while (!i_ready && wait_c < 100) begin
            @(negedge clk);
            wait_c++;
        end
        check({nm, " i_ready"}, 32'(i_ready), 32'd1);
        p0 = r2_pulses;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        lat = 1;
        mid_done = 1'b0;
        while (!o_valid && lat < 5000) begin
            if (fl_mid && lat == 3) begin
                i_flush = 1'b1;
                mid_done = 1'b1;
            end
            @(negedge clk);
            i_flush = 1'b0;
            lat++;
        end
        if (good && !exp_hit && !mid_done) begin
            m_cvalid = 1'b1;
            m_cn = n;
        end
        if (mid_done) m_cvalid = 1'b0;
        check({nm, " o_valid"}, 32'(o_valid), 32'd1);
        check({nm, " crypto"}, 32'(o_crypto), 32'(exp_c));
        check({nm, " tag"}, 32'(o_tag), 32'(t));
        check({nm, " hit"}, 32'(o_cache_hit), 32'(exp_hit));
        check({nm, " err"}, 32'(o_err), 32'(!good));
        check({nm, " r2 starts"}, 32'(r2_pulses - p0), 32'(good && !exp_hit));
        if (!good) check({nm, " err latency"}, 32'(lat), 32'd2);
    endtask

    task automatic ack(input string nm);
        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
        check({nm, " ack o_valid"}, 32'(o_valid), 32'd0);
        check({nm, " ack i_ready"}, 32'(i_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " i_ready"}, 32'(i_ready), 32'd1);
        check({nm, " o_valid"}, 32'(o_valid), 32'd0);
        check({nm, " o_crypto"}, 32'(o_crypto), 32'd0);
        check({nm, " o_tag"}, 32'(o_tag), 32'd0);
        check({nm, " o_cache_hit"}, 32'(o_cache_hit), 32'd0);
        check({nm, " o_err"}, 32'(o_err), 32'd0);
    endtask

    initial begin
        logic [W-1:0] pool [10];
        logic [W-1:0] hold_c;
        int           p0;
        pool = '{8'd33, 8'd35, 8'd221, 8'd251, 8'd34, 8'd1, 8'd127, 8'd255, 8'd45, 8'd9};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // First request misses and fills the cache.
        run_req(8'd5, 8'd3, 8'd33, 4'd1, 1'b0, 1'b0, "t1");
        check("t1 cache r2", 32'(dut.u_cache.r2_q), 32'(ref_r2(8'd33)));
        ack("t1");

        // Same modulus hits.
        run_req(8'd7, 8'd3, 8'd33, 4'd2, 1'b0, 1'b0, "t2");
        ack("t2");

        // Even modulus rejected.
        run_req(8'd9, 8'd4, 8'd34, 4'd3, 1'b0, 1'b0, "t3");
        ack("t3");

        // Back-pressure at DONE keeps outputs stable.
        run_req(8'd9, 8'd5, 8'd33, 4'd4, 1'b0, 1'b0, "t4");
        hold_c = ref_exp(8'd9, 8'd5, 8'd33);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4 hold o_valid", 32'(o_valid), 32'd1);
            check("t4 hold crypto", 32'(o_crypto), 32'(hold_c));
            check("t4 hold i_ready", 32'(i_ready), 32'd0);
        end
        check("t4 hold tag", 32'(o_tag), 32'd4);
        ack("t4");

        // Flush with the accept forces a recompute.
        run_req(8'd11, 8'd7, 8'd33, 4'd5, 1'b1, 1'b0, "t5");
        ack("t5");

        // Flush during precompute: result still right, next same-N request misses.
        run_req(8'd3, 8'd9, 8'd35, 4'd6, 1'b0, 1'b1, "t5b");
        ack("t5b");
        run_req(8'd4, 8'd9, 8'd35, 4'd7, 1'b0, 1'b0, "t5c");
        ack("t5c");

        // Reset in the middle of precompute.
        p0 = r2_pulses;
        i_msg = 8'd5; i_key = 8'd3; i_modulus = 8'd33; i_tag = 4'd9;
        i_flush = 1'b1; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6 precomp started", 32'(r2_pulses - p0), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t6 reset");
        rst = 1'b0;
        m_cvalid = 1'b0;
        @(negedge clk);
        run_req(8'd5, 8'd3, 8'd33, 4'd10, 1'b0, 1'b0, "t6 after");
        ack("t6 after");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 24; i++) begin
            run_req(W'($urandom), W'($urandom), pool[$urandom_range(0, 9)], TW'($urandom),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), "rand");
            ack("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
